// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, lane width.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } dmemSize_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmemState_t;

    localparam int unsigned BE_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-memory request/response bus; master = CPU port, slave = responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_lane_gen.sv
// Store lane placement: byte enables and replicated write data from size/offset.
module dmem_lane_gen
    import dmem_pkg::*;
(
    input  logic [1:0]      addr,
    input  logic [1:0]      size,
    input  logic [31:0]     wdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     lane_wdata,
    output logic            misaligned
);

    always_comb begin
        be         = '0;
        lane_wdata = '0;
        misaligned = 1'b0;
        case (size)
            SIZE_B: begin
                be         = 4'b0001 << addr;
                lane_wdata = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                misaligned = addr[0];
            end
            SIZE_W: begin
                be         = '1;
                lane_wdata = wdata;
                misaligned = |addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data RAM responder: one outstanding request, fixed LATENCY, byte-enabled stores.
// Optional macro DMEM_MISALIGN_CHECK_EN rejects misaligned half/word and adds misalign_o.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LATENCY   = 1,
  parameter string       INIT_FILE = ""
)
(
  input  logic clk,
  input  logic reset,
`ifdef DMEM_MISALIGN_CHECK_EN
  output logic misalign_o,
`endif
  dmem_responder_if.slave bus
);

  dmemState_t         state, nextState;
  logic [3:0]         cnt, nextCnt;
  logic [ADDR_W-1:0]  idxQ, reqIdx, rdIdx;
  logic               errQ, weQ, reqErr, rdErr, rdWe;
  logic               accept, enterResp;
  logic [31:0]        respRdata;
  logic               respErr;
  logic [BE_W-1:0]    be;
  logic [31:0]        laneWdata;
  logic               misaligned;
  logic [31:0]        mem [2**ADDR_W];

  dmem_lane_gen uLaneGen (
    .addr       (bus.req_addr[1:0]),
    .size       (bus.req_size),
    .wdata      (bus.req_wdata),
    .be         (be),
    .lane_wdata (laneWdata),
    .misaligned (misaligned)
  );

  assign reqIdx = bus.req_addr[ADDR_W+1:2];
`ifdef DMEM_MISALIGN_CHECK_EN
  assign reqErr = (|bus.req_addr[31:ADDR_W+2]) | (bus.req_size == SIZE_X) | misaligned;
`else
  logic unusedMisaligned;
  assign unusedMisaligned = misaligned;
  assign reqErr = (|bus.req_addr[31:ADDR_W+2]) | (bus.req_size == SIZE_X);
`endif

  assign accept    = bus.req_valid & (state == IDLE);
  assign enterResp = (nextState == RESP) & (state != RESP);
  // With LATENCY==1 RESP is entered straight from IDLE, before the request is latched.
  assign rdIdx = (state == IDLE) ? reqIdx : idxQ;
  assign rdErr = (state == IDLE) ? reqErr : errQ;
  assign rdWe  = (state == IDLE) ? bus.req_we : weQ;

  always_comb begin
    nextState      = state;
    nextCnt        = cnt;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (LATENCY == 1) begin
            nextState = RESP;
          end else begin
            nextState = WAIT;
            nextCnt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        nextCnt = cnt - 4'd1;
        if (cnt == 4'd1) nextState = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idxQ      <= '0;
      errQ      <= 1'b0;
      weQ       <= 1'b0;
      respRdata <= '0;
      respErr   <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (accept) begin
        idxQ <= reqIdx;
        errQ <= reqErr;
        weQ  <= bus.req_we;
      end
      if (enterResp) begin
        respRdata <= (rdErr | rdWe) ? '0 : mem[rdIdx];
        respErr   <= rdErr;
      end
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) misalign_o <= 1'b0;
    else       misalign_o <= enterResp & rdErr;
  end
`endif

  always_ff @(posedge clk) begin
    if (accept & bus.req_we & ~reqErr & ~reset) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be[b]) mem[reqIdx][8*b +: 8] <= laneWdata[8*b +: 8];
      end
    end
  end

  assign bus.resp_rdata = respRdata;
  assign bus.resp_err   = respErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-array memory model; honours DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;

    localparam int unsigned LAT_A = 3;
    localparam int unsigned LAT_B = 4;

    logic clk = 1'b0;
    logic rstA, rstB;
    always #5 clk = ~clk;

    dmem_responder_if ifA ();
    dmem_responder_if ifB ();
`ifdef DMEM_MISALIGN_CHECK_EN
    logic misalignA, misalignB;
`endif

    dmem_responder #(.ADDR_W(8), .LATENCY(LAT_A), .INIT_FILE("")) dutA (
        .clk        (clk),
        .reset      (rstA),
`ifdef DMEM_MISALIGN_CHECK_EN
        .misalign_o (misalignA),
`endif
        .bus        (ifA)
    );

    dmem_responder #(.ADDR_W(8), .LATENCY(LAT_B), .INIT_FILE("")) dutB (
        .clk        (clk),
        .reset      (rstB),
`ifdef DMEM_MISALIGN_CHECK_EN
        .misalign_o (misalignB),
`endif
        .bus        (ifB)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  refBytes [1024];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory as a flat little-endian byte array; an access of n bytes lands on the n-aligned base.
    function automatic void refOp(input logic [31:0] a, input logic we, input logic [1:0] size,
                                  input logic [31:0] wdata, output logic [31:0] rd, output logic err);
        int unsigned n, base;
        rd  = '0;
        err = (a >= 32'h400) || (size == 2'd3);
`ifdef DMEM_MISALIGN_CHECK_EN
        err = err || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
`endif
        if (err) return;
        if (we) begin
            n    = 32'd1 << size;
            base = a & ~(n - 1);
            for (int unsigned i = 0; i < n; i++) refBytes[base + i] = wdata[8*i +: 8];
        end else begin
            base = a & ~32'd3;
            for (int unsigned i = 0; i < 4; i++) rd[8*i +: 8] = refBytes[base + i];
        end
    endfunction

    task automatic doOp(input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic [31:0] wdata, input int unsigned hold,
                        output logic [31:0] rdata, output logic err);
        logic [31:0] expData, held;
        logic        expErr;
        int unsigned lat;
        bit          got;
        rdata = '0;
        err   = 1'b0;
        refOp(addr, we, size, wdata, expData, expErr);
        checkVal("req_ready_idle", ifA.req_ready, 1);
        ifA.req_addr  = addr;
        ifA.req_we    = we;
        ifA.req_size  = size;
        ifA.req_wdata = wdata;
        ifA.req_valid = 1'b1;
        @(posedge clk); #1;
        ifA.req_valid  = 1'b0;
        ifA.req_addr   = $urandom;
        ifA.req_wdata  = $urandom;
        ifA.req_we     = ~we;
        ifA.resp_ready = 1'($urandom);
        lat = 1;
        got = 0;
        while (!got && lat <= 20) begin
            if (ifA.resp_valid) begin
                got = 1;
                ifA.resp_ready = 1'b0;
            end else begin
                checkVal("req_ready_wait", ifA.req_ready, 0);
                ifA.resp_ready = 1'($urandom);
                @(posedge clk); #1;
                lat++;
            end
        end
        checkVal("resp_seen", got, 1);
        if (!got) return;
        checkVal("latency", lat, LAT_A);
        checkVal("rdata", ifA.resp_rdata, expData);
        checkVal("err", ifA.resp_err, expErr);
`ifdef DMEM_MISALIGN_CHECK_EN
        checkVal("misalign_pulse", misalignA, expErr);
`endif
        rdata = ifA.resp_rdata;
        err   = ifA.resp_err;
        held  = ifA.resp_rdata;
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkVal("hold_valid", ifA.resp_valid, 1);
            checkVal("hold_rdata", ifA.resp_rdata, held);
            checkVal("hold_req_ready", ifA.req_ready, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
            checkVal("misalign_once", misalignA, 0);
`endif
        end
        ifA.resp_ready = 1'b1;
        @(posedge clk); #1;
        ifA.resp_ready = 1'b0;
        checkVal("done_valid", ifA.resp_valid, 0);
        checkVal("done_req_ready", ifA.req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a, wd;
        logic        er, we;
        logic [1:0]  sz;
        int unsigned lat;
        bit          seen, got;

        ifA.req_valid = 1'b0; ifA.req_addr = '0; ifA.req_we = 1'b0;
        ifA.req_size = 2'd2;  ifA.req_wdata = '0; ifA.resp_ready = 1'b0;
        ifB.req_valid = 1'b0; ifB.req_addr = '0; ifB.req_we = 1'b0;
        ifB.req_size = 2'd2;  ifB.req_wdata = '0; ifB.resp_ready = 1'b0;
        rstA = 1'b1;
        rstB = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_req_ready", ifA.req_ready, 1);
        checkVal("rst_resp_valid", ifA.resp_valid, 0);
        checkVal("rst_resp_rdata", ifA.resp_rdata, 0);
        checkVal("rst_resp_err", ifA.resp_err, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        checkVal("rst_misalign", misalignA, 0);
`endif
        rstA = 1'b0;
        rstB = 1'b0;

        for (int unsigned w = 0; w < 32; w++) doOp(32'(w * 4), 1'b1, 2'd2, 32'h0, 0, rd, er);

        doOp(32'h010, 1'b1, 2'd2, 32'hDEADBEEF, 0, rd, er);
        doOp(32'h010, 1'b0, 2'd2, 32'h0, 0, rd, er);
        checkVal("word_ld", rd, 32'hDEADBEEF);
        doOp(32'h020, 1'b1, 2'd2, 32'h11223344, 0, rd, er);
        doOp(32'h022, 1'b1, 2'd0, 32'h000000AB, 0, rd, er);
        doOp(32'h020, 1'b0, 2'd2, 32'h0, 5, rd, er);
        checkVal("byte_merge", rd, 32'h11AB3344);
        doOp(32'h032, 1'b1, 2'd1, 32'h0000CAFE, 0, rd, er);
        doOp(32'h030, 1'b0, 2'd2, 32'h0, 0, rd, er);
        checkVal("half_ld", rd, 32'hCAFE0000);
        doOp(32'h400, 1'b0, 2'd2, 32'h0, 0, rd, er);
        checkVal("oor_err", er, 1);
        checkVal("oor_rdata", rd, 0);
        doOp(32'h010, 1'b1, 2'd3, 32'hFFFFFFFF, 0, rd, er);
        checkVal("illsize_err", er, 1);
        doOp(32'h010, 1'b0, 2'd2, 32'h0, 0, rd, er);
        checkVal("illsize_unchanged", rd, 32'hDEADBEEF);

        for (int unsigned k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
            else                           a = $urandom_range(0, 127);
            we = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            doOp(a, we, sz, wd, $urandom_range(0, 3), rd, er);
        end

        // Second responder: reset lands while the store is still counting down.
        ifB.req_addr = 32'h040; ifB.req_we = 1'b1; ifB.req_size = 2'd2;
        ifB.req_wdata = 32'h5A5AA5A5; ifB.req_valid = 1'b1;
        @(posedge clk); #1;
        ifB.req_valid = 1'b0;
        ifB.req_addr  = '0;
        @(posedge clk); #1;
        rstB = 1'b1;
        @(posedge clk); #1;
        rstB = 1'b0;
        checkVal("rstB_req_ready", ifB.req_ready, 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ifB.resp_valid) seen = 1;
        end
        checkVal("rstB_no_resp", seen, 0);
        ifB.req_addr = 32'h040; ifB.req_we = 1'b0; ifB.req_size = 2'd2; ifB.req_valid = 1'b1;
        @(posedge clk); #1;
        ifB.req_valid = 1'b0;
        lat = 1;
        got = 0;
        while (!got && lat <= 20) begin
            if (ifB.resp_valid) got = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        checkVal("rstB_resp_seen", got, 1);
        checkVal("rstB_latency", lat, LAT_B);
        checkVal("rstB_rdata", ifB.resp_rdata, 32'h5A5AA5A5);
        checkVal("rstB_err", ifB.resp_err, 0);
        ifB.resp_ready = 1'b1;
        @(posedge clk); #1;
        ifB.resp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
